// File: rtl/reg_scoreboard_pkg.sv
// Shared scoreboard constants, register-address type and the per-register counter update rule.
// Optional feature: SCOREBOARD_FWD_EN (only load results are tracked when defined).
package reg_scoreboard_pkg;

  localparam int SB_REG_NUM      = 32;
  localparam int SB_CNT_W        = 2;
  localparam int SB_MAX_INFLIGHT = (1 << SB_CNT_W) - 1;
  localparam int REG_ADDR_W      = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_CLR
  } cnt_op_e;

  // Flush wins; a simultaneous issue and retire on one register cancel out.
  function automatic cnt_op_e cnt_op(input logic clr, input logic inc, input logic dec,
                                     input logic nz, input logic sat);
    cnt_op_e op;
    op = CNT_HOLD;
    if (clr)
      op = CNT_CLR;
    else if (inc && dec)
      op = CNT_HOLD;
    else if (inc && !sat)
      op = CNT_INC;
    else if (dec && nz)
      op = CNT_DEC;
    return op;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID/WB-side bundle of the register scoreboard: decoded operands, retire port and stall/issue view.
interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int REG_NUM = SB_REG_NUM
);

  logic               flush;
  logic               id_valid;
  logic               id_read_en_1;
  reg_addr_t          id_addr_1;
  logic               id_read_en_2;
  reg_addr_t          id_addr_2;
  logic               id_write_en;
  reg_addr_t          id_write_addr;
  logic               id_is_load;
  logic               wb_en;
  reg_addr_t          wb_addr;
  logic               stall;
  logic               issue;
  logic [REG_NUM-1:0] pending_mask;

  modport master (
    output flush, id_valid, id_read_en_1, id_addr_1, id_read_en_2, id_addr_2,
           id_write_en, id_write_addr, id_is_load, wb_en, wb_addr,
    input  stall, issue, pending_mask
  );

  modport slave (
    input  flush, id_valid, id_read_en_1, id_addr_1, id_read_en_2, id_addr_2,
           id_write_en, id_write_addr, id_is_load, wb_en, wb_addr,
    output stall, issue, pending_mask
  );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register in-flight write counter: saturates at all-ones and never underflows.
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nz
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  cnt_op_e op;

  assign nz = (cnt != '0);

  always_comb begin
    op = cnt_op(clr, inc, dec, nz, &cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case (op)
        CNT_CLR: cnt <= '0;
        CNT_INC: cnt <= cnt + CNT_ONE;
        CNT_DEC: cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage RAW scoreboard: counts in-flight GPR writes and stalls dependent instructions.
// Optional feature: SCOREBOARD_FWD_EN (EX/MEM forwarding present, only loads are tracked).
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int REG_NUM = SB_REG_NUM,
  parameter int CNT_W   = SB_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  reg_scoreboard_if.slave   sb
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   cnt [REG_NUM];
  logic [REG_NUM-1:0] nz;
  logic [REG_NUM-1:0] inc;
  logic [REG_NUM-1:0] dec;

  logic [CNT_W-1:0] cnt_1;
  logic [CNT_W-1:0] cnt_2;
  logic [CNT_W-1:0] cnt_w;
  logic             hazard_1;
  logic             hazard_2;
  logic             full;
  logic             tracked_kind;
  logic             track;

  // With forwarding only load results are late enough to need an interlock.
`ifdef SCOREBOARD_FWD_EN
  assign tracked_kind = sb.id_write_en && sb.id_is_load;
`else
  assign tracked_kind = sb.id_write_en;
`endif

  assign cnt_1 = cnt[sb.id_addr_1];
  assign cnt_2 = cnt[sb.id_addr_2];
  assign cnt_w = cnt[sb.id_write_addr];

  // A retire of the last pending write to a source frees that source in the same cycle.
  assign hazard_1 = sb.id_read_en_1 && (sb.id_addr_1 != '0) && (cnt_1 != '0)
                 && !(sb.wb_en && (sb.wb_addr == sb.id_addr_1) && (cnt_1 == CNT_ONE));
  assign hazard_2 = sb.id_read_en_2 && (sb.id_addr_2 != '0) && (cnt_2 != '0)
                 && !(sb.wb_en && (sb.wb_addr == sb.id_addr_2) && (cnt_2 == CNT_ONE));
  assign full     = tracked_kind && (sb.id_write_addr != '0) && (cnt_w == CNT_MAX);

  assign sb.stall = sb.id_valid && !sb.flush && (hazard_1 || hazard_2 || full);
  assign sb.issue = sb.id_valid && !sb.stall && !sb.flush;
  assign track    = sb.issue && tracked_kind && (sb.id_write_addr != '0);

  assign sb.pending_mask = nz;

  // r0 is hardwired zero and never gets a counter.
  for (genvar i = 0; i < REG_NUM; i++) begin : g_reg
    assign inc[i] = track && (sb.id_write_addr == reg_addr_t'(i));
    assign dec[i] = sb.wb_en && (sb.wb_addr == reg_addr_t'(i));
    if (i == 0) begin : g_zero
      assign cnt[i] = '0;
      assign nz[i]  = 1'b0;
    end else begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (sb.flush),
        .inc (inc[i]),
        .dec (dec[i]),
        .cnt (cnt[i]),
        .nz  (nz[i])
      );
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard; expectations adapt to SCOREBOARD_FWD_EN.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   pass_count = 0;
  int   check_count = 0;

`ifdef SCOREBOARD_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_scoreboard_if #(.REG_NUM(SB_REG_NUM)) sb_bus ();

  reg_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_bus.slave)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    if (observed === expected)
      pass_count++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic apply_stimulus(input logic valid, input logic re1, input int a1,
                                input logic re2, input int a2, input logic we,
                                input int wa, input logic ld);
    sb_bus.id_valid      = valid;
    sb_bus.id_read_en_1  = re1;
    sb_bus.id_addr_1     = reg_addr_t'(a1);
    sb_bus.id_read_en_2  = re2;
    sb_bus.id_addr_2     = reg_addr_t'(a2);
    sb_bus.id_write_en   = we;
    sb_bus.id_write_addr = reg_addr_t'(wa);
    sb_bus.id_is_load    = ld;
    #1;
  endtask

  task automatic set_wb(input logic en, input int addr);
    sb_bus.wb_en   = en;
    sb_bus.wb_addr = reg_addr_t'(addr);
    #1;
  endtask

  task automatic idle();
    sb_bus.flush = 1'b0;
    set_wb(1'b0, 0);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("reset_stall", 32'(sb_bus.stall), 32'd0);
    check_output("reset_issue", 32'(sb_bus.issue), 32'd0);
    check_output("reset_mask", sb_bus.pending_mask, 32'd0);

    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    check_output("noread_issue", 32'(sb_bus.issue), 32'd1);
    check_output("noread_stall", 32'(sb_bus.stall), 32'd0);
    step();

    // ADDU r3, then a dependent read held until WB r3 bypasses it.
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 3, 1'b0);
    check_output("r3_write_issue", 32'(sb_bus.issue), 32'd1);
    step();
    apply_stimulus(1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 0, 1'b0);
    check_output("r3_raw_stall", 32'(sb_bus.stall), 32'd1);
    check_output("r3_raw_issue", 32'(sb_bus.issue), 32'd0);
    check_output("r3_mask", sb_bus.pending_mask, 32'h0000_0008);
    step();
    check_output("r3_still_stall", 32'(sb_bus.stall), 32'd1);
    step();
    set_wb(1'b1, 3);
    check_output("r3_bypass_stall", 32'(sb_bus.stall), 32'd0);
    check_output("r3_bypass_issue", 32'(sb_bus.issue), 32'd1);
    step();
    idle();
    check_output("r3_mask_clear", sb_bus.pending_mask, 32'd0);

    // Saturate r5 with three writes; the fourth stalls on full.
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 5, 1'b0);
      check_output("r5_fill_issue", 32'(sb_bus.issue), 32'd1);
      step();
    end
    check_output("r5_cnt3", 32'(dut.cnt[5]), 32'd3);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 5, 1'b0);
    check_output("r5_full_stall", 32'(sb_bus.stall), 32'd1);
    check_output("r5_full_issue", 32'(sb_bus.issue), 32'd0);
    set_wb(1'b1, 5);
    check_output("r5_full_wb_stall", 32'(sb_bus.stall), 32'd1);
    step();
    set_wb(1'b0, 0);
    check_output("r5_cnt2", 32'(dut.cnt[5]), 32'd2);
    check_output("r5_fourth_issue", 32'(sb_bus.issue), 32'd1);
    step();
    idle();
    check_output("r5_cnt3_again", 32'(dut.cnt[5]), 32'd3);
    set_wb(1'b1, 5);
    for (int k = 0; k < 3; k++) step();
    set_wb(1'b0, 0);
    check_output("r5_drained_mask", sb_bus.pending_mask, 32'd0);

    // Same-cycle issue and retire on r7 cancel; flush then clears everything.
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 10, 1'b0);
    step();
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 7, 1'b0);
    step();
    set_wb(1'b1, 7);
    check_output("r7_same_issue", 32'(sb_bus.issue), 32'd1);
    step();
    set_wb(1'b0, 0);
    check_output("r7_cnt_held", 32'(dut.cnt[7]), 32'd1);
    check_output("r7_r10_mask", sb_bus.pending_mask, 32'h0000_0480);
    apply_stimulus(1'b1, 1'b1, 7, 1'b0, 0, 1'b1, 11, 1'b0);
    sb_bus.flush = 1'b1;
    #1;
    check_output("flush_issue", 32'(sb_bus.issue), 32'd0);
    check_output("flush_stall", 32'(sb_bus.stall), 32'd0);
    step();
    idle();
    check_output("flush_mask", sb_bus.pending_mask, 32'd0);
    set_wb(1'b1, 7);
    step();
    set_wb(1'b0, 0);
    check_output("r7_no_underflow", 32'(dut.cnt[7]), 32'd0);
    check_output("r7_post_mask", sb_bus.pending_mask, 32'd0);

    // r0 is never tracked and never causes a hazard.
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0);
    check_output("r0_write_issue", 32'(sb_bus.issue), 32'd1);
    step();
    check_output("r0_mask", sb_bus.pending_mask, 32'd0);
    apply_stimulus(1'b1, 1'b1, 0, 1'b1, 0, 1'b0, 0, 1'b0);
    check_output("r0_read_stall", 32'(sb_bus.stall), 32'd0);
    check_output("r0_read_issue", 32'(sb_bus.issue), 32'd1);
    step();

    // Hazard through source port 2, released by the WB bypass.
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 12, 1'b0);
    step();
    apply_stimulus(1'b1, 1'b0, 0, 1'b1, 12, 1'b0, 0, 1'b0);
    check_output("r12_port2_stall", 32'(sb_bus.stall), 32'd1);
    set_wb(1'b1, 12);
    check_output("r12_bypass_stall", 32'(sb_bus.stall), 32'd0);
    step();
    idle();
    check_output("r12_mask_clear", sb_bus.pending_mask, 32'd0);

    // ALU write vs load write on r4: forwarding removes only the ALU interlock.
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 4, 1'b0);
    step();
    apply_stimulus(1'b1, 1'b1, 4, 1'b0, 0, 1'b0, 0, 1'b0);
    check_output("r4_alu_stall", 32'(sb_bus.stall), FWD ? 32'd0 : 32'd1);
    check_output("r4_alu_mask", sb_bus.pending_mask, FWD ? 32'd0 : 32'h0000_0010);
    idle();
    set_wb(1'b1, 4);
    step();
    set_wb(1'b0, 0);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 4, 1'b1);
    step();
    apply_stimulus(1'b1, 1'b1, 4, 1'b0, 0, 1'b0, 0, 1'b0);
    check_output("r4_load_stall", 32'(sb_bus.stall), 32'd1);
    step();
    check_output("r4_load_stall2", 32'(sb_bus.stall), 32'd1);
    set_wb(1'b1, 4);
    check_output("r4_load_release", 32'(sb_bus.stall), 32'd0);
    step();
    idle();
    check_output("r4_mask_clear", sb_bus.pending_mask, 32'd0);

    // Two pending writes to r9: a single retire does not bypass; async reset drops the stall.
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 9, 1'b0);
    step();
    step();
    check_output("r9_cnt2", 32'(dut.cnt[9]), 32'd2);
    apply_stimulus(1'b1, 1'b1, 9, 1'b0, 0, 1'b0, 0, 1'b0);
    set_wb(1'b1, 9);
    check_output("r9_no_bypass_stall", 32'(sb_bus.stall), 32'd1);
    set_wb(1'b0, 0);
    rst = 1'b1;
    #1;
    check_output("rst_async_stall", 32'(sb_bus.stall), 32'd0);
    check_output("rst_async_mask", sb_bus.pending_mask, 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("rst_release_mask", sb_bus.pending_mask, 32'd0);
    check_output("rst_release_cnt9", 32'(dut.cnt[9]), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
